// File: rtl/qspi_pkg.sv
// -----------------------------------------------------------------------------
// qspi_pkg
// Shared definitions for the single-lane QSPI command master: FSM state
// encoding, common flash opcodes, the expected manufacturer ID and the address
// width. Also holds the helper that picks the phase following the header.
// -----------------------------------------------------------------------------
package qspi_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_CMD     = 3'd1,
      ST_ADDR    = 3'd2,
      ST_DUMMY   = 3'd3,
      ST_READ    = 3'd4,
      ST_HOLD    = 3'd5,
      ST_CS_IDLE = 3'd6
   } state_t;

   localparam logic [7:0] OP_RDID = 8'h9F;
   localparam logic [7:0] OP_READ = 8'h03;
   localparam logic [7:0] OP_WREN = 8'h06;
   localparam logic [7:0] OP_RDSR = 8'h05;

   localparam logic [7:0] MFR_ID  = 8'hC2;

   localparam int ADDR_BITS = 24;

   // Phase that follows the opcode/address header: dummy clocks first if any,
   // then the read phase if any bytes are requested, otherwise straight to hold.
   function automatic state_t phase_after_hdr(input logic dummy_nz, input logic read_nz);
      state_t nxt;
      if (dummy_nz)
         nxt = ST_DUMMY;
      else if (read_nz)
         nxt = ST_READ;
      else
         nxt = ST_HOLD;
      return nxt;
   endfunction

endpackage

// File: rtl/qspi_sclk_gen.sv
// -----------------------------------------------------------------------------
// qspi_sclk_gen
// Serial clock divider. Each sclk half lasts CLK_DIV clk cycles, low half first.
// While disabled the divider is parked with sclk low and the half counter clear,
// so the first enabled cycle is the first clk of a low half.
//
// Ports:
//   clk           in   system clock
//   resetn        in   asynchronous active-low reset
//   i_en          in   run the divider (low = park sclk low, counter cleared)
//   i_park        in   suppress the low->high transition at the end of a low half
//   o_sclk        out  serial clock level
//   o_rise_tick   out  last clk of a low half (sclk rises next cycle)
//   o_fall_tick   out  last clk of a high half (sclk falls next cycle)
//   o_sample_tick out  last clk of a high half, used to capture io1
// -----------------------------------------------------------------------------
module qspi_sclk_gen #(
   parameter int CLK_DIV = 2
) (
   input  logic clk,
   input  logic resetn,
   input  logic i_en,
   input  logic i_park,
   output logic o_sclk,
   output logic o_rise_tick,
   output logic o_fall_tick,
   output logic o_sample_tick
);

   localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   if (CLK_DIV < 1) begin : g_bad_div
      $error("qspi_sclk_gen: CLK_DIV must be >= 1");
   end

   logic [CW-1:0] r_cnt;
   logic          r_sclk;
   logic          w_last;

   assign w_last = (r_cnt == CW'(CLK_DIV - 1));

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_cnt  <= '0;
         r_sclk <= 1'b0;
      end else if (!i_en) begin
         r_cnt  <= '0;
         r_sclk <= 1'b0;
      end else if (w_last) begin
         r_cnt <= '0;
         // A parked low half wraps without rising, keeping sclk low through hold.
         if (r_sclk || !i_park)
            r_sclk <= ~r_sclk;
      end else begin
         r_cnt <= r_cnt + CW'(1);
      end
   end

   assign o_sclk        = r_sclk;
   assign o_rise_tick   = i_en & w_last & ~r_sclk;
   assign o_fall_tick   = i_en & w_last & r_sclk;
   assign o_sample_tick = i_en & w_last & r_sclk;

endmodule

// File: rtl/qspi_cmd_master.sv
// -----------------------------------------------------------------------------
// qspi_cmd_master
// SPI mode-0 single-lane command engine. Runs one transaction at a time:
// 8-bit opcode, optional 24-bit address, optional dummy clocks and an optional
// read of rd_len bytes, all MSB-first. io0 carries opcode/address and changes
// only while sclk is low; io1 is captured in the last clk of each sclk-high half.
//
// Ports:
//   clk, resetn           system clock, asynchronous active-low reset
//   start                 request; taken only while busy=0
//   cmd, addr_en, addr    opcode, address-phase enable, address
//   dummy_cycles, rd_len  dummy sclk count (0..15), bytes to read (0 = none)
//   busy, done            transaction active, one-cycle completion pulse
//   rd_data, rd_valid     last received byte, one-cycle pulse per byte
//   qspi_sclk, qspi_cs_n  serial clock (idle low), chip select (idle high)
//   qspi_io0_o/_oe        io0 drive value and enable
//   qspi_io1_i            io1 data from the flash
//   qspi_io2_o/io3_o      WP# / HOLD#, tied high
// -----------------------------------------------------------------------------
module qspi_cmd_master
   import qspi_pkg::*;
#(
   parameter int CLK_DIV = 2,
   parameter int LEN_W   = 8
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             start,
   input  logic [7:0]       cmd,
   input  logic             addr_en,
   input  logic [23:0]      addr,
   input  logic [3:0]       dummy_cycles,
   input  logic [LEN_W-1:0] rd_len,
   output logic             busy,
   output logic             done,
   output logic [7:0]       rd_data,
   output logic             rd_valid,
   output logic             qspi_sclk,
   output logic             qspi_cs_n,
   output logic             qspi_io0_o,
   output logic             qspi_io0_oe,
   input  logic             qspi_io1_i,
   output logic             qspi_io2_o,
   output logic             qspi_io3_o
);

   localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   state_t           r_state;
   logic             r_cs_n;
   logic             r_oe;
   logic [31:0]      r_sh;
   logic [4:0]       r_bit_cnt;
   logic [LEN_W-1:0] r_byte_cnt;
   logic [CW-1:0]    r_cs_cnt;
   logic [7:0]       r_rd_data;
   logic             r_rd_valid;
   logic             r_done;

   // Transaction descriptor captured at acceptance; no reset needed.
   logic             r_addr_en;
   logic [3:0]       r_dummy;
   logic [LEN_W-1:0] r_rd_len;
   logic [6:0]       r_rx;

   logic             w_gen_en;
   logic             w_park;
   logic             w_sclk;
   logic             w_rise;
   logic             w_fall;
   logic             w_sample;
   logic             w_accept;
   logic             w_rd_nz;
   state_t           w_after_hdr;

   assign w_gen_en    = (r_state != ST_IDLE) && (r_state != ST_CS_IDLE);
   assign w_park      = (r_state == ST_HOLD);
   assign w_accept    = (r_state == ST_IDLE) && start;
   assign w_rd_nz     = (r_rd_len != '0);
   assign w_after_hdr = phase_after_hdr(r_dummy != 4'd0, w_rd_nz);

   qspi_sclk_gen #(
      .CLK_DIV (CLK_DIV)
   ) u_sclk_gen (
      .clk           (clk),
      .resetn        (resetn),
      .i_en          (w_gen_en),
      .i_park        (w_park),
      .o_sclk        (w_sclk),
      .o_rise_tick   (w_rise),
      .o_fall_tick   (w_fall),
      .o_sample_tick (w_sample)
   );

   always_ff @(posedge clk) begin
      if (w_accept) begin
         r_addr_en <= addr_en;
         r_dummy   <= dummy_cycles;
         r_rd_len  <= rd_len;
      end
      if (w_sample && (r_state == ST_READ))
         r_rx <= {r_rx[5:0], qspi_io1_i};
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state    <= ST_IDLE;
         r_cs_n     <= 1'b1;
         r_oe       <= 1'b0;
         r_sh       <= '0;
         r_bit_cnt  <= '0;
         r_byte_cnt <= '0;
         r_cs_cnt   <= '0;
         r_rd_data  <= '0;
         r_rd_valid <= 1'b0;
         r_done     <= 1'b0;
      end else begin
         r_done     <= 1'b0;
         r_rd_valid <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (start) begin
                  // io0 presents cmd[7] from the very first low half.
                  r_sh       <= {cmd, (addr_en ? addr : 24'h0)};
                  r_oe       <= 1'b1;
                  r_cs_n     <= 1'b0;
                  r_bit_cnt  <= '0;
                  r_byte_cnt <= '0;
                  r_state    <= ST_CMD;
               end
            end
            ST_CMD: begin
               if (w_fall) begin
                  r_sh <= {r_sh[30:0], 1'b0};
                  if (r_bit_cnt == 5'd7) begin
                     r_bit_cnt <= '0;
                     if (r_addr_en) begin
                        r_state <= ST_ADDR;
                     end else begin
                        r_state <= w_after_hdr;
                        r_oe    <= 1'b0;
                     end
                  end else begin
                     r_bit_cnt <= r_bit_cnt + 5'd1;
                  end
               end
            end
            ST_ADDR: begin
               if (w_fall) begin
                  r_sh <= {r_sh[30:0], 1'b0};
                  if (r_bit_cnt == 5'(ADDR_BITS - 1)) begin
                     r_bit_cnt <= '0;
                     r_state   <= w_after_hdr;
                     r_oe      <= 1'b0;
                  end else begin
                     r_bit_cnt <= r_bit_cnt + 5'd1;
                  end
               end
            end
            ST_DUMMY: begin
               if (w_fall) begin
                  if (r_bit_cnt[3:0] == (r_dummy - 4'd1)) begin
                     r_bit_cnt <= '0;
                     r_state   <= phase_after_hdr(1'b0, w_rd_nz);
                  end else begin
                     r_bit_cnt <= r_bit_cnt + 5'd1;
                  end
               end
            end
            ST_READ: begin
               if (w_sample) begin
                  if (r_bit_cnt == 5'd7) begin
                     r_rd_data  <= {r_rx, qspi_io1_i};
                     r_rd_valid <= 1'b1;
                     r_bit_cnt  <= '0;
                     if (r_byte_cnt == (r_rd_len - LEN_W'(1)))
                        r_state <= ST_HOLD;
                     else
                        r_byte_cnt <= r_byte_cnt + LEN_W'(1);
                  end else begin
                     r_bit_cnt <= r_bit_cnt + 5'd1;
                  end
               end
            end
            ST_HOLD: begin
               // One parked low half with cs_n still asserted.
               if (w_rise) begin
                  r_state  <= ST_CS_IDLE;
                  r_cs_n   <= 1'b1;
                  r_cs_cnt <= '0;
               end
            end
            ST_CS_IDLE: begin
               if (r_cs_cnt == CW'(CLK_DIV - 1)) begin
                  r_state <= ST_IDLE;
                  r_done  <= 1'b1;
               end else begin
                  r_cs_cnt <= r_cs_cnt + CW'(1);
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign busy        = (r_state != ST_IDLE);
   assign done        = r_done;
   assign rd_data     = r_rd_data;
   assign rd_valid    = r_rd_valid;
   assign qspi_sclk   = w_sclk;
   assign qspi_cs_n   = r_cs_n;
   assign qspi_io0_o  = r_sh[31];
   assign qspi_io0_oe = r_oe;
   assign qspi_io2_o  = 1'b1;
   assign qspi_io3_o  = 1'b1;

endmodule

// File: tb/tb_qspi_cmd_master.sv
// -----------------------------------------------------------------------------
// tb_qspi_cmd_master
// Two masters (CLK_DIV=2 and CLK_DIV=1), each attached to a small behavioural
// flash model that answers RDID, READ and FAST READ. Expected read bytes are
// queued when a transaction is issued and popped on every rd_valid.
// -----------------------------------------------------------------------------
module tb_qspi_cmd_master;
   import qspi_pkg::*;

   logic        clk = 1'b0;
   logic        resetn;
   logic [1:0]  start_v;
   logic [7:0]  cmd;
   logic        addr_en;
   logic [23:0] addr;
   logic [3:0]  dummy;
   logic [7:0]  rd_len;

   logic [1:0]  w_busy, w_done, w_rdv, w_sclk, w_csn, w_io0, w_oe, w_io1, w_io2, w_io3;
   logic [7:0]  w_rdd [2];

   int          n_assert = 0;
   int          n_fail   = 0;
   logic [7:0]  sb[$];

   always #5 clk = ~clk;

   // Flash memory image: RDID returns C2 20 16, array reads return (addr^5A).
   function automatic logic [7:0] dev_byte(input logic [7:0] op, input logic [23:0] a, input int i);
      logic [7:0]  b;
      logic [23:0] p;
      if (op == OP_RDID) begin
         case (i)
            0:       b = MFR_ID;
            1:       b = 8'h20;
            2:       b = 8'h16;
            default: b = 8'h00;
         endcase
      end else begin
         p = a + 24'(i);
         b = p[7:0] ^ 8'h5A;
      end
      return b;
   endfunction

   // Bit driven for the sclk cycle that starts after k rising edges.
   function automatic logic dev_bit(input logic [7:0] op, input logic [23:0] a, input int k);
      int         hdr;
      int         j;
      logic [7:0] b;
      case (op)
         8'h9F:   hdr = 8;
         8'h03:   hdr = 32;
         8'h0B:   hdr = 40;
         default: hdr = -1;
      endcase
      if (hdr < 0 || k < hdr) return 1'b0;
      j = k - hdr;
      b = dev_byte(op, a, j / 8);
      return b[7 - (j % 8)];
   endfunction

   for (genvar g = 0; g < 2; g++) begin : g_dut
      int          d_rise = 0;
      logic [7:0]  d_op   = 8'h00;
      logic [23:0] d_addr = 24'h0;
      logic        d_io1  = 1'b0;

      qspi_cmd_master #(
         .CLK_DIV ((g == 0) ? 2 : 1),
         .LEN_W   (8)
      ) u_dut (
         .clk          (clk),
         .resetn       (resetn),
         .start        (start_v[g]),
         .cmd          (cmd),
         .addr_en      (addr_en),
         .addr         (addr),
         .dummy_cycles (dummy),
         .rd_len       (rd_len),
         .busy         (w_busy[g]),
         .done         (w_done[g]),
         .rd_data      (w_rdd[g]),
         .rd_valid     (w_rdv[g]),
         .qspi_sclk    (w_sclk[g]),
         .qspi_cs_n    (w_csn[g]),
         .qspi_io0_o   (w_io0[g]),
         .qspi_io0_oe  (w_oe[g]),
         .qspi_io1_i   (w_io1[g]),
         .qspi_io2_o   (w_io2[g]),
         .qspi_io3_o   (w_io3[g])
      );

      assign w_io1[g] = d_io1;

      always @(posedge w_sclk[g] or posedge w_csn[g]) begin
         if (w_csn[g]) begin
            d_rise = 0;
         end else begin
            if (d_rise < 8)
               d_op = {d_op[6:0], w_io0[g]};
            else if (d_rise < 32)
               d_addr = {d_addr[22:0], w_io0[g]};
            d_rise = d_rise + 1;
         end
      end

      always @(negedge w_sclk[g] or posedge w_csn[g]) begin
         if (w_csn[g]) begin
            d_io1 = 1'b0;
         end else begin
            #1;
            d_io1 = dev_bit(d_op, d_addr, d_rise);
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_assert++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic run_txn(input int k, input logic [7:0] op, input logic aen, input logic [23:0] a,
                          input logic [3:0] dum, input int len, input int glitch);
      int          h, hdr, nb, cyc, ncs, nbusy, nrise, nvalid, first_oe0, done_cyc;
      logic [31:0] io_bits, exp_bits;
      logic        ps, oe_ok, fin, idle_bad;
      h     = (k == 0) ? 2 : 1;
      hdr   = aen ? 32 : 8;
      nb    = hdr + int'(dum) + 8 * len;
      for (int i = 0; i < len; i++) sb.push_back(dev_byte(op, a, i));
      @(negedge clk);
      cmd = op; addr_en = aen; addr = a; dummy = dum; rd_len = 8'(len);
      start_v[k] = 1'b1;
      cyc = 0; ncs = 0; nbusy = 0; nrise = 0; nvalid = 0;
      first_oe0 = -1; done_cyc = -1; io_bits = '0; ps = 1'b0; oe_ok = 1'b1; fin = 1'b0;
      while (!fin) begin
         @(negedge clk);
         cyc++;
         if (cyc == 1) begin
            start_v[k] = 1'b0;
            chk("c1_busy", w_busy[k], 1);
            chk("c1_cs_n", w_csn[k], 0);
            chk("c1_sclk", w_sclk[k], 0);
            chk("c1_oe",   w_oe[k], 1);
            chk("c1_io0",  w_io0[k], op[7]);
         end
         if (cyc == glitch)     start_v[k] = 1'b1;
         if (cyc == glitch + 1) start_v[k] = 1'b0;
         if (w_sclk[k] && !ps) begin
            nrise++;
            if (nrise <= hdr) begin
               io_bits = {io_bits[30:0], w_io0[k]};
               if (!w_oe[k]) oe_ok = 1'b0;
            end else if (w_oe[k]) begin
               oe_ok = 1'b0;
            end
         end
         ps = w_sclk[k];
         if (!w_oe[k] && first_oe0 < 0) first_oe0 = cyc;
         if (!w_csn[k]) ncs++;
         if (w_busy[k]) nbusy++;
         if (w_rdv[k]) begin
            nvalid++;
            if (sb.size() > 0) chk("rd_data", w_rdd[k], sb.pop_front());
            else               chk("rd_valid_live_count", nvalid, len);
         end
         if (w_done[k]) begin
            done_cyc = cyc;
            chk("busy_at_done", w_busy[k], 0);
            fin = 1'b1;
         end else if (cyc >= 4000) begin
            chk("done_timeout", cyc, 2 * h * nb + 2 * h + 1);
            fin = 1'b1;
         end
      end
      chk("done_cycle", done_cyc, 2 * h * nb + 2 * h + 1);
      chk("sclk_rises", nrise, nb);
      chk("rd_valid_count", nvalid, len);
      exp_bits = aen ? {op, a} : {24'h0, op};
      chk("io0_stream", io_bits, exp_bits);
      chk("io0_oe_at_rise", oe_ok, 1);
      chk("cs_low_cycles", ncs, 2 * h * nb + h);
      chk("busy_cycles", nbusy, 2 * h * nb + 2 * h);
      if (hdr < nb) chk("oe_fall_cycle", first_oe0, 2 * h * hdr + 1);
      chk("sb_empty", sb.size(), 0);
      sb.delete();
      idle_bad = 1'b0;
      repeat (6) begin
         @(negedge clk);
         if (w_busy[k] || w_done[k] || w_rdv[k]) idle_bad = 1'b1;
      end
      chk("idle_after_done", idle_bad, 0);
   endtask

   initial begin
      int   cyc;
      int   nv;
      logic seen_done;

      resetn  = 1'b0;
      start_v = 2'b00;
      cmd     = 8'h00;
      addr_en = 1'b0;
      addr    = 24'h0;
      dummy   = 4'd0;
      rd_len  = 8'd0;
      repeat (3) @(negedge clk);
      chk("rst_busy",     w_busy[0], 0);
      chk("rst_done",     w_done[0], 0);
      chk("rst_rd_valid", w_rdv[0], 0);
      chk("rst_rd_data",  w_rdd[0], 0);
      chk("rst_sclk",     w_sclk[0], 0);
      chk("rst_cs_n",     w_csn[0], 1);
      chk("rst_io0",      w_io0[0], 0);
      chk("rst_oe",       w_oe[0], 0);
      chk("io2_wp",       w_io2[0], 1);
      chk("io3_hold",     w_io3[0], 1);
      chk("rst_cs_n_div1", w_csn[1], 1);
      resetn = 1'b1;
      repeat (2) @(negedge clk);

      // RDID, three ID bytes
      run_txn(0, OP_RDID, 1'b0, 24'h0, 4'd0, 3, -1);
      // WREN, command only, with a start pulse while busy at cycle 10
      run_txn(0, OP_WREN, 1'b0, 24'h0, 4'd0, 0, 10);
      // READ with address
      run_txn(0, OP_READ, 1'b1, 24'h123456, 4'd0, 2, -1);
      // FAST READ with 8 dummy clocks
      run_txn(0, 8'h0B, 1'b1, 24'h00FFFF, 4'd8, 1, -1);

      // Reset in the high half of READ bit 12 (overall bit 20) of an RDID
      @(negedge clk);
      cmd = OP_RDID; addr_en = 1'b0; addr = 24'h0; dummy = 4'd0; rd_len = 8'd3;
      start_v[0] = 1'b1;
      cyc = 0; nv = 0; seen_done = 1'b0;
      while (cyc < 83) begin
         @(negedge clk);
         cyc++;
         if (cyc == 1) start_v[0] = 1'b0;
         if (w_done[0]) seen_done = 1'b1;
         if (w_rdv[0]) begin
            nv++;
            chk("abort_byte0", w_rdd[0], MFR_ID);
         end
      end
      chk("abort_pre_sclk", w_sclk[0], 1);
      chk("abort_pre_cs_n", w_csn[0], 0);
      resetn = 1'b0;
      #1;
      chk("abort_cs_n", w_csn[0], 1);
      chk("abort_sclk", w_sclk[0], 0);
      chk("abort_busy", w_busy[0], 0);
      repeat (3) begin
         @(negedge clk);
         if (w_done[0]) seen_done = 1'b1;
      end
      resetn = 1'b1;
      @(negedge clk);
      if (w_done[0]) seen_done = 1'b1;
      chk("abort_no_done", seen_done, 0);
      chk("abort_bytes", nv, 1);
      run_txn(0, OP_RDID, 1'b0, 24'h0, 4'd0, 1, -1);

      // CLK_DIV=1 instance
      run_txn(1, OP_RDID, 1'b0, 24'h0, 4'd0, 1, -1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
